// File: rtl/display_pkg.sv
// Shared constants and types for the LED matrix row-scan scheduler.
package display_pkg;

  localparam int P1_COL    = 2;
  localparam int P2_COL    = 11;
  localparam int DIGIT_ROW = 2;

  // Glyph rows written as seen on the matrix: MSB is the leftmost pixel.
  localparam logic [0:9][0:4][2:0] DIGIT_FONT = '{
    '{3'b111, 3'b101, 3'b101, 3'b101, 3'b111},
    '{3'b010, 3'b110, 3'b010, 3'b010, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b100, 3'b111},
    '{3'b111, 3'b001, 3'b111, 3'b001, 3'b111},
    '{3'b101, 3'b101, 3'b111, 3'b001, 3'b001},
    '{3'b111, 3'b100, 3'b111, 3'b001, 3'b111},
    '{3'b111, 3'b100, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b001, 3'b001, 3'b001, 3'b001},
    '{3'b111, 3'b101, 3'b111, 3'b101, 3'b111},
    '{3'b111, 3'b101, 3'b111, 3'b001, 3'b111}
  };

  typedef enum logic {ACTIVE, BLANK} state_t;

  typedef struct packed {
    logic [15:0] lpaddle;
    logic [15:0] rpaddle;
    logic [3:0]  ball_x;
    logic [3:0]  ball_y;
    logic [3:0]  score_p1;
    logic [3:0]  score_p2;
    logic        show_score;
  } snap_t;

endpackage

// File: rtl/display_scheduler_if.sv
// Game-side image sources in, matrix row/column drive out.
interface display_scheduler_if;
  logic [15:0] lpaddle;
  logic [15:0] rpaddle;
  logic [3:0]  ball_x;
  logic [3:0]  ball_y;
  logic [3:0]  score_p1;
  logic [3:0]  score_p2;
  logic        show_score;
  logic [3:0]  row;
  logic [15:0] col;
  logic        frame_start;

  modport master (
    output lpaddle, rpaddle, ball_x, ball_y, score_p1, score_p2, show_score,
    input  row, col, frame_start
  );
  modport slave (
    input  lpaddle, rpaddle, ball_x, ball_y, score_p1, score_p2, show_score,
    output row, col, frame_start
  );
endinterface

// File: rtl/digit_font.sv
// 3x5 digit glyph row lookup; bits[0] is the leftmost pixel.
module digit_font
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic [2:0] line,
  output logic [2:0] bits
);
  always_comb begin
    bits = '0;
    if (digit <= 4'd9 && line <= 3'd4) begin
      for (int i = 0; i < 3; i++) bits[i] = DIGIT_FONT[digit][line][2-i];
    end
  end
endmodule

// File: rtl/display_scheduler.sv
// Row-scan scheduler: one row per slot, optional blanking, per-frame snapshot of all sources.
module display_scheduler
  import display_pkg::*;
#(
  parameter int ROW_CYCLES   = 4,
  parameter int BLANK_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  display_scheduler_if.slave bus
);
  state_t      state, state_n;
  logic [7:0]  dwell, dwell_n;
  logic [3:0]  cur_row, row_n;
  snap_t       shadow, live, src;
  logic        enter_frame, in_digit;
  logic [2:0]  line, p1_bits, p2_bits;
  logic [15:0] col_n;

  assign live = '{lpaddle: bus.lpaddle, rpaddle: bus.rpaddle, ball_x: bus.ball_x,
                  ball_y: bus.ball_y, score_p1: bus.score_p1, score_p2: bus.score_p2,
                  show_score: bus.show_score};

  always_comb begin
    state_n = state;
    dwell_n = dwell - 8'd1;
    row_n   = cur_row;
    if (dwell == 8'd0) begin
      if (state == ACTIVE && BLANK_CYCLES != 0) begin
        state_n = BLANK;
        dwell_n = 8'(BLANK_CYCLES - 1);
      end else begin
        state_n = ACTIVE;
        dwell_n = 8'(ROW_CYCLES - 1);
        row_n   = cur_row + 4'd1;
      end
    end
    enter_frame = (dwell == 8'd0) && (state_n == ACTIVE) && (row_n == 4'd0);
  end

  // Row 0 is drawn from the values being captured this edge, later rows from the shadow.
  assign src      = enter_frame ? live : shadow;
  assign in_digit = src.show_score && row_n >= 4'(DIGIT_ROW) && row_n <= 4'(DIGIT_ROW + 4);
  assign line     = 3'(row_n - 4'(DIGIT_ROW));

  digit_font u_p1 (.digit(src.score_p1), .line(line), .bits(p1_bits));
  digit_font u_p2 (.digit(src.score_p2), .line(line), .bits(p2_bits));

  always_comb begin
    col_n = '0;
    if (state_n == ACTIVE) begin
      col_n[0]  = src.lpaddle[row_n];
      col_n[15] = src.rpaddle[row_n];
      if (!src.show_score && row_n == src.ball_y) col_n[src.ball_x] = 1'b1;
      if (in_digit) begin
        col_n[P1_COL +: 3] = col_n[P1_COL +: 3] | p1_bits;
        col_n[P2_COL +: 3] = col_n[P2_COL +: 3] | p2_bits;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= BLANK;
      dwell           <= '0;
      cur_row         <= 4'hF;
      shadow          <= '0;
      bus.row         <= '0;
      bus.col         <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      state           <= state_n;
      dwell           <= dwell_n;
      cur_row         <= row_n;
      if (enter_frame) shadow <= live;
      bus.row         <= row_n;
      bus.col         <= col_n;
      bus.frame_start <= enter_frame;
    end
  end
endmodule

// File: tb/tb_display_scheduler.sv
// Scoreboard bench: two scheduler instances (default timing and 1/0 timing) checked cycle by cycle.
module tb_display_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic give_up = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  display_scheduler_if bus0 ();
  display_scheduler_if bus1 ();

  display_scheduler #(.ROW_CYCLES(4), .BLANK_CYCLES(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  display_scheduler #(.ROW_CYCLES(1), .BLANK_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  typedef struct {
    int          cyc;
    int          which;
    logic [3:0]  row;
    logic [15:0] col;
    logic        fs;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t me;

  task automatic push(input exp_t e);
    int i = q.size();
    while (i > 0 && q[i-1].cyc > e.cyc) i--;
    q.insert(i, e);
  endtask

  task automatic push_at(input int c, input int w, input logic [3:0] r, input logic [15:0] cl,
                         input logic f, input string nm);
    exp_t e;
    e.cyc = c; e.which = w; e.row = r; e.col = cl; e.fs = f; e.name = nm;
    push(e);
  endtask

  task automatic push_frame(input int w, input int f, input int rc, input int bc,
                            input logic [15:0] tbl [16], input int nrows, input string nm);
    int per = rc + bc;
    for (int r = 0; r < nrows; r++)
      for (int j = 0; j < per; j++)
        push_at(f + r*per + j, w, 4'(r), (j < rc) ? tbl[r] : 16'h0, (r == 0 && j == 0), nm);
  endtask

  task automatic set_in(input logic [15:0] lp, input logic [15:0] rp, input logic [3:0] bx,
                        input logic [3:0] by, input logic [3:0] s1, input logic [3:0] s2,
                        input logic sh);
    bus0.lpaddle = lp; bus0.rpaddle = rp; bus0.ball_x = bx; bus0.ball_y = by;
    bus0.score_p1 = s1; bus0.score_p2 = s2; bus0.show_score = sh;
    bus1.lpaddle = lp; bus1.rpaddle = rp; bus1.ball_x = bx; bus1.ball_y = by;
    bus1.score_p1 = s1; bus1.score_p2 = s2; bus1.show_score = sh;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: every negedge, retire all expectations due at or before this cycle.
  always @(negedge clk) begin
    if (give_up && q.size() > 0) begin
      compared   = compared + q.size();
      mismatched = mismatched + q.size();
      $display("FAIL timeout: %0d expected entries never reached, want 0", q.size());
      q.delete();
    end
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      logic [3:0]  gr;
      logic [15:0] gc;
      logic        gf;
      me = q.pop_front();
      gr = (me.which == 0) ? bus0.row : bus1.row;
      gc = (me.which == 0) ? bus0.col : bus1.col;
      gf = (me.which == 0) ? bus0.frame_start : bus1.frame_start;
      compared = compared + 1;
      if (me.cyc != cyc || gr !== me.row || gc !== me.col || gf !== me.fs) begin
        mismatched = mismatched + 1;
        $display("FAIL %s dut%0d cyc=%0d(at %0d): got row=%0d col=%h fs=%b, want row=%0d col=%h fs=%b",
                 me.name, me.which, me.cyc, cyc, gr, gc, gf, me.row, me.col, me.fs);
      end
    end
  end

  logic [15:0] t [16];

  initial begin
    set_in(16'hFFFF, 16'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    push_at(2, 0, 4'd0, 16'h0, 1'b0, "reset_state");
    push_at(2, 1, 4'd0, 16'h0, 1'b0, "reset_state");

    wait_cyc(3);
    reset = 1'b0;
    t = '{default: 16'h0001};
    push_frame(0, 4, 4, 1, t, 16, "defaults_f0");
    push_frame(0, 84, 4, 1, t, 16, "defaults_f1");

    wait_cyc(100);
    set_in(16'h0070, 16'h0E00, 4'd7, 4'd5, 4'd0, 4'd0, 1'b0);
    t = '{default: 16'h0};
    t[4] = 16'h0001; t[5] = 16'h0081; t[6] = 16'h0001;
    t[9] = 16'h8000; t[10] = 16'h8000; t[11] = 16'h8000;
    push_frame(0, 164, 4, 1, t, 16, "paddles_ball");

    wait_cyc(180);
    set_in(16'h0, 16'h0, 4'd3, 4'd4, 4'd1, 4'd9, 1'b1);
    t = '{default: 16'h0};
    t[2] = 16'h3808; t[3] = 16'h280C; t[4] = 16'h3808; t[5] = 16'h2008; t[6] = 16'h381C;
    push_frame(0, 244, 4, 1, t, 16, "score_1_9");

    wait_cyc(260);
    set_in(16'h0, 16'h0, 4'd5, 4'd2, 4'd0, 4'd0, 1'b0);
    t = '{default: 16'h0};
    t[2] = 16'h0020;
    push_frame(0, 324, 4, 1, t, 16, "snap_old_y");
    t = '{default: 16'h0};
    t[12] = 16'h0020;
    push_frame(0, 404, 4, 1, t, 16, "snap_new_y");
    wait_cyc(356);
    bus0.ball_y = 4'd12; bus1.ball_y = 4'd12;

    wait_cyc(420);
    set_in(16'h0, 16'h0, 4'd5, 4'd12, 4'd7, 4'd12, 1'b1);
    t = '{default: 16'h0};
    t[2] = 16'h001C; t[3] = 16'h0010; t[4] = 16'h0010; t[5] = 16'h0010; t[6] = 16'h0010;
    push_frame(0, 484, 4, 1, t, 9, "score_7_blank");

    wait_cyc(530);
    reset = 1'b1;
    for (int c = 531; c <= 532; c++) begin
      push_at(c, 0, 4'd0, 16'h0, 1'b0, "midframe_reset");
      push_at(c, 1, 4'd0, 16'h0, 1'b0, "midframe_reset");
    end
    set_in(16'hFFFF, 16'h0, 4'd15, 4'd0, 4'd0, 4'd0, 1'b0);
    t = '{default: 16'h0001};
    t[0] = 16'h8001;
    push_frame(0, 533, 4, 1, t, 16, "restart");
    for (int m = 0; m < 3; m++) push_frame(1, 533 + 16*m, 1, 0, t, 16, "fast_scan");
    wait_cyc(532);
    reset = 1'b0;

    while (q.size() > 0 && cyc < 800) @(negedge clk);
    if (q.size() > 0) give_up = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
